// File: rtl/sprite_line_renderer_pkg.sv
// Shared constants and types for the sprite line renderer.
// Orientation codes, sprite geometry, VGA timing, fetch states.
package sprite_line_renderer_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } orient_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int SPRITE_W = 8;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;

  // Line following v, wrapping to 0 after the last line of the frame.
  function automatic logic [9:0] next_line(
    input logic [9:0] v,
    input int         total
  );
    return (int'(v) == total - 1) ? 10'd0 : v + 10'd1;
  endfunction

endpackage

// File: rtl/sprite_fetch_ctrl.sv
// Per-line sprite fetch sequencer: issues one ROM read per slot,
// then tags the returned row with its slot for capture.
module sprite_fetch_ctrl #(
  parameter int SLOTS      = 4,
  parameter int SCALE_LOG2 = 1,
  parameter int LINES      = 525
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       line_start,
  input  logic [9:0]                 vpos,
  input  logic [SLOTS-1:0]           slot_valid,
  input  logic [SLOTS*10-1:0]        slot_x,
  input  logic [SLOTS*10-1:0]        slot_y,
  input  logic [SLOTS*4-1:0]         slot_id,
  input  logic [SLOTS*2-1:0]         slot_orient,
  output logic                       fetch_busy,
  output logic                       rom_read_enable,
  output logic [3:0]                 rom_sprite_ID,
  output logic [2:0]                 rom_line_index,
  output logic [1:0]                 rom_orientation,
  output logic                       cap_valid,
  output logic [$clog2(SLOTS)-1:0]   cap_slot,
  output logic                       cap_hit,
  output logic [9:0]                 cap_x
);
  import sprite_line_renderer_pkg::*;

  localparam int SW = $clog2(SLOTS);
  localparam logic [9:0] SPAN = 10'(SPRITE_W << SCALE_LOG2);

  fetch_state_t  state_q, state_d;
  logic [SW-1:0] cnt_q;
  logic [9:0]    line_q;
  logic          issue, last, hit;
  logic [9:0]    d, cur_x, cur_y;
  logic [3:0]    cur_id;
  logic [1:0]    cur_or;

  assign issue  = (state_q == ISSUE);
  assign last   = (cnt_q == SW'(SLOTS - 1));
  assign cur_x  = slot_x[int'(cnt_q)*10 +: 10];
  assign cur_y  = slot_y[int'(cnt_q)*10 +: 10];
  assign cur_id = slot_id[int'(cnt_q)*4 +: 4];
  assign cur_or = slot_orient[int'(cnt_q)*2 +: 2];
  assign d      = line_q - cur_y;
  assign hit    = issue && slot_valid[cnt_q] && (d < SPAN);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: trigger only from idle, one cycle per slot, one drain
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (line_start) state_d = ISSUE;
      ISSUE:   if (last)       state_d = DRAIN;
      DRAIN:                   state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Slot counter, target line and capture tag for the returning row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      line_q    <= '0;
      cap_valid <= 1'b0;
      cap_slot  <= '0;
      cap_hit   <= 1'b0;
      cap_x     <= '0;
    end else begin
      cnt_q     <= (issue && !last) ? cnt_q + SW'(1) : '0;
      if (state_q == IDLE && line_start)
        line_q  <= next_line(vpos, LINES);
      cap_valid <= issue;
      cap_slot  <= cnt_q;
      cap_hit   <= hit;
      cap_x     <= cur_x;
    end
  end

  // ROM request driven only on a hitting issue cycle
  always_comb begin
    fetch_busy      = (state_q != IDLE);
    rom_read_enable = hit;
    rom_sprite_ID   = hit ? cur_id : 4'd0;
    rom_orientation = hit ? cur_or : 2'd0;
    rom_line_index  = hit ? 3'(d >> SCALE_LOG2) : 3'd0;
  end

endmodule

// File: rtl/sprite_line_renderer.sv
// Sprite line renderer: fetches per-slot sprite rows during hblank
// and composites them against the scan position.
module sprite_line_renderer #(
  parameter int SLOTS      = 4,
  parameter int SCALE_LOG2 = 1,
  parameter int V_TOTAL    = 525
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               hpos,
  input  logic [9:0]               vpos,
  input  logic                     line_start,
  input  logic [SLOTS-1:0]         slot_valid,
  input  logic [SLOTS*10-1:0]      slot_x,
  input  logic [SLOTS*10-1:0]      slot_y,
  input  logic [SLOTS*4-1:0]       slot_id,
  input  logic [SLOTS*2-1:0]       slot_orient,
  output logic                     rom_read_enable,
  output logic [3:0]               rom_sprite_ID,
  output logic [2:0]               rom_line_index,
  output logic [1:0]               rom_orientation,
  input  logic [7:0]               rom_data,
  output logic                     pixel_on,
  output logic [$clog2(SLOTS)-1:0] pixel_slot,
  output logic                     fetch_busy
);
  import sprite_line_renderer_pkg::*;

  localparam int PW = $clog2(SLOTS);
  localparam logic [9:0] SPAN = 10'(SPRITE_W << SCALE_LOG2);

  logic          cap_valid, cap_hit;
  logic [PW-1:0] cap_slot;
  logic [9:0]    cap_x;

  logic [7:0]       line_buf [SLOTS];
  logic [9:0]       x_q      [SLOTS];
  logic [SLOTS-1:0] hit_q;

  logic          any;
  logic [PW-1:0] first;
  logic [9:0]    c;
  logic [2:0]    idx;

  sprite_fetch_ctrl #(
    .SLOTS      (SLOTS),
    .SCALE_LOG2 (SCALE_LOG2),
    .LINES      (V_TOTAL)
  ) u_fetch (
    .clk             (clk),
    .reset           (reset),
    .line_start      (line_start),
    .vpos            (vpos),
    .slot_valid      (slot_valid),
    .slot_x          (slot_x),
    .slot_y          (slot_y),
    .slot_id         (slot_id),
    .slot_orient     (slot_orient),
    .fetch_busy      (fetch_busy),
    .rom_read_enable (rom_read_enable),
    .rom_sprite_ID   (rom_sprite_ID),
    .rom_line_index  (rom_line_index),
    .rom_orientation (rom_orientation),
    .cap_valid       (cap_valid),
    .cap_slot        (cap_slot),
    .cap_hit         (cap_hit),
    .cap_x           (cap_x)
  );

  // Line buffers: a slot is overwritten only in its own capture cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < SLOTS; k++) begin
        line_buf[k] <= 8'hFF;
        x_q[k]      <= '0;
      end
      hit_q <= '0;
    end else if (cap_valid) begin
      line_buf[cap_slot] <= cap_hit ? rom_data : 8'hFF;
      hit_q[cap_slot]    <= cap_hit;
      x_q[cap_slot]      <= cap_x;
    end
  end

  // Compositor: scan high to low so the lowest covering slot wins
  always_comb begin
    any   = 1'b0;
    first = '0;
    c     = '0;
    idx   = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      c   = hpos - x_q[k];
      idx = 3'(c >> SCALE_LOG2);
      if (hit_q[k] && (c < SPAN) && !line_buf[k][idx]) begin
        any   = 1'b1;
        first = PW'(k);
      end
    end
  end

  // Pixel outputs registered one cycle behind hpos
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_on   <= 1'b0;
      pixel_slot <= '0;
    end else begin
      pixel_on   <= any;
      pixel_slot <= first;
    end
  end

endmodule
